// File: rtl/ptw_axi_arbiter.sv
// ptw_axi_arbiter: serialises ITLB/DTLB PTE reads onto one AXI read channel with round-robin
// priority and routes each returned PTE back to its requester.
module ptw_axi_arbiter #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  I_ADDR_VALID,
    input  logic [ADDR_WIDTH-1:0] I_ADDR,
    output logic                  I_DATA_VALID,
    output logic [DATA_WIDTH-1:0] I_DATA,
    output logic                  I_ACCESS_ERR,
    input  logic                  D_ADDR_VALID,
    input  logic [ADDR_WIDTH-1:0] D_ADDR,
    output logic                  D_DATA_VALID,
    output logic [DATA_WIDTH-1:0] D_DATA,
    output logic                  D_ACCESS_ERR,
    output logic                  M_ARVALID,
    input  logic                  M_ARREADY,
    output logic [ADDR_WIDTH-1:0] M_ARADDR,
    output logic [7:0]            M_ARLEN,
    output logic [2:0]            M_ARSIZE,
    output logic [1:0]            M_ARBURST,
    output logic [2:0]            M_ARPROT,
    input  logic                  M_RVALID,
    output logic                  M_RREADY,
    input  logic [DATA_WIDTH-1:0] M_RDATA,
    input  logic [1:0]            M_RRESP,
    input  logic                  M_RLAST
);
    localparam logic [1:0] IDLE = 2'd0, AR = 2'd1, R = 2'd2, RET = 2'd3;
    logic [1:0] state_q, state_d;
    // 1 selects the DTLB; last_q remembers the winner of the last contested arbitration
    logic gnt_q, gnt_d, last_q, last_d;
    logic i_pend_q, i_pend_d, d_pend_q, d_pend_d;
    logic [ADDR_WIDTH-1:0] i_addr_q, i_addr_d, d_addr_q, d_addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic err_q, err_d;
    logic in_flight, i_acc, d_acc, i_req, d_req, tie, pick, grant, ar_hs, r_hs;
    logic unused;

    assign M_ARLEN   = 8'd0;
    assign M_ARSIZE  = 3'b011;
    assign M_ARBURST = 2'b01;
    assign M_ARPROT  = 3'b001;
    assign unused    = ^{M_RLAST, M_RRESP[0], I_ADDR[2:0], D_ADDR[2:0]};

    always_comb begin
        in_flight = state_q == AR || state_q == R;
        i_acc     = I_ADDR_VALID && !i_pend_q && !(in_flight && !gnt_q);
        d_acc     = D_ADDR_VALID && !d_pend_q && !(in_flight && gnt_q);
        i_req     = i_pend_q || i_acc;
        d_req     = d_pend_q || d_acc;
        tie       = i_req && d_req;
        pick      = tie ? !last_q : d_req;
        // Granting from RET lets a waiting request start its AR right after the return pulse
        grant     = (state_q == IDLE || state_q == RET) && (i_req || d_req);
        ar_hs     = state_q == AR && M_ARREADY;
        r_hs      = state_q == R && M_RVALID;
        state_d   = grant ? AR : (state_q == AR) ? (M_ARREADY ? R : AR) :
                    (state_q == R) ? (M_RVALID ? RET : R) : IDLE;
        gnt_d     = grant ? pick : gnt_q;
        last_d    = (grant && tie) ? pick : last_q;
        i_pend_d  = i_acc || (i_pend_q && !(ar_hs && !gnt_q));
        d_pend_d  = d_acc || (d_pend_q && !(ar_hs && gnt_q));
        i_addr_d  = i_acc ? {I_ADDR[ADDR_WIDTH-1:3], 3'b000} : i_addr_q;
        d_addr_d  = d_acc ? {D_ADDR[ADDR_WIDTH-1:3], 3'b000} : d_addr_q;
        data_d    = r_hs ? (M_RRESP[1] ? '0 : M_RDATA) : data_q;
        err_d     = r_hs ? M_RRESP[1] : err_q;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            gnt_q    <= 1'b0;
            last_q   <= 1'b1;
            i_pend_q <= 1'b0;
            d_pend_q <= 1'b0;
            i_addr_q <= '0;
            d_addr_q <= '0;
            data_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            last_q   <= last_d;
            i_pend_q <= i_pend_d;
            d_pend_q <= d_pend_d;
            i_addr_q <= i_addr_d;
            d_addr_q <= d_addr_d;
            data_q   <= data_d;
            err_q    <= err_d;
        end
    end

    assign M_ARVALID    = state_q == AR;
    assign M_ARADDR     = M_ARVALID ? (gnt_q ? d_addr_q : i_addr_q) : '0;
    assign M_RREADY     = state_q == R;
    assign I_DATA_VALID = state_q == RET && !gnt_q;
    assign D_DATA_VALID = state_q == RET && gnt_q;
    assign I_DATA       = I_DATA_VALID ? data_q : '0;
    assign D_DATA       = D_DATA_VALID ? data_q : '0;
    assign I_ACCESS_ERR = I_DATA_VALID && err_q;
    assign D_ACCESS_ERR = D_DATA_VALID && err_q;
endmodule
